// File: rtl/arth_serial_ctrl_pkg.sv
// Shared op codes, FSM states and op-decode helpers
// for the bit-serial arithmetic sequencer.
package arth_serial_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_PASS = 2'b00,
    OP_ADD  = 2'b01,
    OP_SUB  = 2'b10,
    OP_INC  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  // SUB is a + ~b + 1 and INC is a + 0 + 1: both seed carry with 1
  function automatic logic init_cin(op_e op);
    return (op == OP_SUB) || (op == OP_INC);
  endfunction

  function automatic logic y_sel(op_e op, logic b);
    logic y;
    y = 1'b0;
    unique case (1'b1)
      (op == OP_ADD): y = b;
      (op == OP_SUB): y = ~b;
      default:        y = 1'b0;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/arth_serial_ctrl_if.sv
// Operand/result handshake bundle between the CPU-side
// operand registers and the serial arithmetic sequencer.
interface arth_serial_ctrl_if #(
  parameter int WIDTH = 8
);

  logic             start_in;
  logic [1:0]       op_in;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             ready_out;
  logic             busy_out;
  logic             done_out;
  logic [WIDTH-1:0] result_out;
  logic             carry_out;
  logic             overflow_out;

  modport master (
    output start_in,
    output op_in,
    output a_in,
    output b_in,
    input  ready_out,
    input  busy_out,
    input  done_out,
    input  result_out,
    input  carry_out,
    input  overflow_out
  );

  modport slave (
    input  start_in,
    input  op_in,
    input  a_in,
    input  b_in,
    output ready_out,
    output busy_out,
    output done_out,
    output result_out,
    output carry_out,
    output overflow_out
  );

endinterface

// File: rtl/arth_serial_ctrl_bit_cell.sv
// Shared 1-bit arithmetic cell: {cout,sum} = a + y + cin.
module arth_bit_cell (
  input  logic a,
  input  logic y,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ y ^ cin;
  assign cout = (a & y) | (cin & (a ^ y));

endmodule

// File: rtl/arth_serial_ctrl.sv
// Bit-serial PASS/ADD/SUB/INC sequencer, LSB first,
// one bit per clock through the shared 1-bit cell.
module arth_serial_ctrl
  import arth_serial_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic         clk_in,
  input  logic         rst_in,
  arth_serial_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(WIDTH - 1);

  state_e state_q;
  state_e state_d;

  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-2:0] res_sr;
  op_e              op_q;
  logic             carry_q;

  logic [WIDTH-1:0] result_q;
  logic             cout_q;
  logic             ovf_q;

  logic             accept;
  logic             last;
  logic             cell_y;
  logic             cell_sum;
  logic             cell_cout;
  logic [WIDTH-1:0] res_nx;

  assign last   = (cnt_q == LAST);
  assign cell_y = y_sel(op_q, b_sr[0]);
  assign res_nx = {cell_sum, res_sr};

  arth_bit_cell u_cell (
    .a    (a_sr[0]),
    .y    (cell_y),
    .cin  (carry_q),
    .sum  (cell_sum),
    .cout (cell_cout)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start_in) begin
          accept  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (last) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt_q    <= '0;
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      op_q     <= OP_PASS;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (accept) begin
      cnt_q   <= '0;
      a_sr    <= bus.a_in;
      b_sr    <= bus.b_in;
      op_q    <= op_e'(bus.op_in);
      carry_q <= init_cin(op_e'(bus.op_in));
    end else if (state_q == S_RUN) begin
      cnt_q   <= cnt_q + CNT_W'(1);
      a_sr    <= a_sr >> 1;
      b_sr    <= b_sr >> 1;
      res_sr  <= res_nx[WIDTH-1:1];
      carry_q <= cell_cout;
      // carry_q is the carry into the MSB on the last bit
      if (last) begin
        result_q <= res_nx;
        cout_q   <= (op_q == OP_PASS) ? 1'b0 : cell_cout;
        ovf_q    <= (op_q == OP_PASS) ? 1'b0
                    : (carry_q ^ cell_cout);
      end
    end
  end

  assign bus.ready_out    = (state_q == S_IDLE);
  assign bus.busy_out     = (state_q == S_RUN) ||
                            (state_q == S_DONE);
  assign bus.done_out     = (state_q == S_DONE);
  assign bus.result_out   = result_q;
  assign bus.carry_out    = cout_q;
  assign bus.overflow_out = ovf_q;

endmodule
